spi_xfer_core: RTL
==================

Name: spi_xfer_core

Overview:
Serial transfer engine that drives the SPI pin bundle (sck, nss, io_en, io_out, io_in) toward the pad ring. It takes byte frames from the upstream register/FIFO stage over a valid/ready handshake and serializes them in std (1-bit), dual (2-bit) or quad (4-bit) mode with programmable CPOL/CPHA and clock divider. Received bytes are returned as single-cycle pulses, and a done pulse feeds the irq logic.

Parameters:
NSS_NUM, 4, number of chip-select lines; equals SPI_NSS_NUM.
DIV_W, 8, width of the clock divider field.

Ports:
clk_i  input  1  system clock
rst_n_i  input  1  async active-low reset
cpol_i  input  1  SCK idle level
cpha_i  input  1  0: sample on leading edge; 1: sample on trailing edge
lsb_i  input  1  1: LSB first
mode_i  input  2  0 std, 1 dual, 2 quad, 3 reserved (treated as std)
rxonly_i  input  1  dual/quad only: io lines are inputs for this frame
div_i  input  DIV_W  SCK half-period = div_i+1 clk cycles
nss_sel_i  input  NSS_NUM  one-hot slave select (active-high here, driven low on pin)
tx_valid_i  input  1  frame request
tx_ready_o  output  1  core can accept a frame
tx_data_i  input  8  byte to send
tx_last_i  input  1  release NSS after this frame
rx_valid_o  output  1  one-cycle pulse, rx_data_o valid
rx_data_o  output  8  received byte
busy_o  output  1  NSS asserted or shifting
done_o  output  1  one-cycle pulse when a last frame completes and NSS is released
spi_sck_o  output  1  serial clock
spi_nss_o  output  NSS_NUM  chip selects, active-low
spi_io_en_o  output  4  per-line output enable
spi_io_out_o  output  4  output data
spi_io_in_i  input  4  input data (already synchronized at pad level)

Behaviour:
- Reset: sck=0, nss=all 1, io_en=0, io_out=0, rx_valid=0, rx_data=0, done=0, busy=0, FSM=IDLE.
- tx_ready_o = (state==IDLE || state==WAIT). It is combinational and therefore 1 immediately after reset.
- In IDLE, spi_sck_o tracks cpol_i with a one-cycle register delay.
- Config (cpol, cpha, lsb, mode, rxonly, div, nss_sel, last) and tx_data are latched on the handshake cycle. Input changes afterwards are ignored until the next handshake.
- States:
  - IDLE: on handshake, latch config, drive nss (~nss_sel), go to SETUP.
  - SETUP: one half-period with sck idle. For CPHA0, the first data is driven on entry. Then go to SHIFT.
  - SHIFT: counter reloads to div each half-period; sck toggles on reload. Number of edge pairs = 8 (std), 4 (dual), 2 (quad).
    - CPHA0: sample on leading edge, shift out on trailing edge.
    - CPHA1: shift out on leading edge, sample on trailing edge.
    - After the final edge pair, sck is back at idle level. Go to HOLD.
  - HOLD: one half-period. Then rx_valid pulses with the assembled byte.
    - If last: release nss, pulse done, go to IDLE.
    - Otherwise: go to WAIT.
  - WAIT: nss stays asserted.
    - On handshake, latch the new byte and go to SETUP. The new cpol/div/mode are taken; nss_sel is kept from the first frame.
    - No timeout.
- Lane mapping:
  - std: out on io0, in from io1, io_en=0001.
  - dual: io[1:0], io_en=0011.
  - quad: io[3:0], io_en=1111.
  - Bit order within a lane group follows lsb_i. In MSB-first dual mode, io1 carries the higher bit.
  - rxonly (dual/quad): io_en=0000 for the whole frame.
  - std is always full duplex.
  - io_en drops to 0 in HOLD/WAIT/IDLE.
- Frame timing, div=0, std: handshake at cycle 0, nss low at cycle 1, first sck edge at cycle 2, rx_valid at cycle 19, nss high at cycle 19 if last.
- General frame length from handshake to rx_valid: 1 + (2*edgepairs+2)*(div+1) cycles.
- Async reset mid-frame: all outputs return to reset values at once. No rx_valid or done is emitted.
- tx_valid while busy in SETUP/SHIFT/HOLD is not accepted (ready=0). Upstream must hold the request.
- mode=3 behaves exactly as std.

Test Plan:
- Std, cpol=0, cpha=0, div=0, tx 0xA5, last=1, io1 looped to io0 -> 8 sck pulses, MSB-first pattern 1,0,1,0,0,1,0,1 on io0, rx_data=0xA5, done pulse, nss back to all-1 at cycle 19.
- Std, cpol=1, cpha=1, div=3, lsb=1, tx 0x3C, slave model returns 0x81 -> sck idles high, half-period 4 clks, rx_data=0x81, frame length 1+18*4=73 cycles.
- Quad, rxonly=1, div=1, io_in drives 0xD then 0x2 -> io_en=0000 throughout, 2 sck pulses, rx_data=0xD2.
- Two frames back-to-back, 0x11 (last=0) then 0x22 (last=1), with tx_valid delayed 5 cycles -> nss stays low through WAIT, two rx_valid pulses, one done pulse.
- Reset asserted mid-SHIFT of dual frame -> sck=0, nss=all-1, io_en=0 immediately; no rx_valid; tx_ready=1 after release.
- Dual, tx 0xB4, MSB-first, cpha=0 -> io[1:0] sequence 10,11,01,00; io_en=0011 during SHIFT only.

Source files
------------

// File: rtl/spi_xfer_core.sv
// spi_xfer_core: byte-frame SPI shift engine with std/dual/quad lanes,
// programmable CPOL/CPHA, bit order and SCK divider.
module spi_xfer_core #(
    parameter int NSS_NUM = 4,
    parameter int DIV_W   = 8
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               cpol_i,
    input  logic               cpha_i,
    input  logic               lsb_i,
    input  logic [1:0]         mode_i,
    input  logic               rxonly_i,
    input  logic [DIV_W-1:0]   div_i,
    input  logic [NSS_NUM-1:0] nss_sel_i,
    input  logic               tx_valid_i,
    output logic               tx_ready_o,
    input  logic [7:0]         tx_data_i,
    input  logic               tx_last_i,
    output logic               rx_valid_o,
    output logic [7:0]         rx_data_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               spi_sck_o,
    output logic [NSS_NUM-1:0] spi_nss_o,
    output logic [3:0]         spi_io_en_o,
    output logic [3:0]         spi_io_out_o,
    input  logic [3:0]         spi_io_in_i
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_WAIT
    } state_t;

    state_t state;
    state_t state_next;

    logic             cpol_q;
    logic             cpha_q;
    logic             lsb_q;
    logic [1:0]       mode_q;
    logic [DIV_W-1:0] div_q;
    logic             last_q;
    logic [DIV_W-1:0] cnt;
    logic [3:0]       half_idx;
    logic [7:0]       tx_sh;
    logic [7:0]       rx_sh;

    logic       hs;
    logic       half_end;
    logic [1:0] mode_in;
    logic [3:0] last_half;
    logic [3:0] event_idx;
    logic       sck_event;
    logic       shift_end;
    logic       frame_end;
    logic       lead_evt;
    logic       do_sample;
    logic       do_drive;

    // Lane group presented on io_out for the current shift register content.
    function automatic logic [3:0] tx_group(input logic [7:0] sh, input logic [1:0] mode,
                                            input logic lsb);
        logic [3:0] g;
        g = 4'b0000;
        case (mode)
            2'd1:    g = {2'b00, (lsb ? sh[1:0] : sh[7:6])};
            2'd2:    g = lsb ? sh[3:0] : sh[7:4];
            default: g = {3'b000, (lsb ? sh[0] : sh[7])};
        endcase
        return g;
    endfunction

    // Drop the group just presented and line up the next one.
    function automatic logic [7:0] tx_shift(input logic [7:0] sh, input logic [1:0] mode,
                                            input logic lsb);
        logic [7:0] r;
        r = sh;
        case (mode)
            2'd1:    r = lsb ? {2'b00, sh[7:2]} : {sh[5:0], 2'b00};
            2'd2:    r = lsb ? {4'b0000, sh[7:4]} : {sh[3:0], 4'b0000};
            default: r = lsb ? {1'b0, sh[7:1]} : {sh[6:0], 1'b0};
        endcase
        return r;
    endfunction

    // Merge one sampled lane group into the receive byte; std receives on io1.
    function automatic logic [7:0] rx_insert(input logic [7:0] rx, input logic [3:0] io,
                                             input logic [1:0] mode, input logic lsb);
        logic [7:0] r;
        r = rx;
        case (mode)
            2'd1:    r = lsb ? {io[1:0], rx[7:2]} : {rx[5:0], io[1:0]};
            2'd2:    r = lsb ? {io[3:0], rx[7:4]} : {rx[3:0], io[3:0]};
            default: r = lsb ? {io[1], rx[7:1]} : {rx[6:0], io[1]};
        endcase
        return r;
    endfunction

    // Output-enable pattern for a frame; rxonly only applies to dual/quad.
    function automatic logic [3:0] lane_en(input logic [1:0] mode, input logic rxonly);
        logic [3:0] e;
        case (mode)
            2'd1:    e = rxonly ? 4'b0000 : 4'b0011;
            2'd2:    e = rxonly ? 4'b0000 : 4'b1111;
            default: e = 4'b0001;
        endcase
        return e;
    endfunction

    assign mode_in    = (mode_i == 2'd3) ? 2'd0 : mode_i;
    assign tx_ready_o = (state == ST_IDLE) || (state == ST_WAIT);
    assign hs         = tx_valid_i && tx_ready_o;
    assign busy_o     = (state != ST_IDLE);
    assign half_end   = (cnt == '0);
    assign lead_evt   = ~event_idx[0];
    assign do_sample  = sck_event && (cpha_q ? ~lead_evt : lead_evt);
    assign do_drive   = sck_event && (cpha_q ? lead_evt
                                             : (~lead_evt && (event_idx != last_half)));

    // State register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and the per-half-period SCK edge strobes.
    always_comb begin
        state_next = state;
        sck_event  = 1'b0;
        shift_end  = 1'b0;
        frame_end  = 1'b0;
        event_idx  = half_idx + 4'd1;
        case (mode_q)
            2'd1:    last_half = 4'd7;
            2'd2:    last_half = 4'd3;
            default: last_half = 4'd15;
        endcase
        case (state)
            ST_IDLE: begin
                if (hs) state_next = ST_SETUP;
            end
            ST_SETUP: begin
                if (half_end) begin
                    state_next = ST_SHIFT;
                    sck_event  = 1'b1;
                    event_idx  = 4'd0;
                end
            end
            ST_SHIFT: begin
                if (half_end) begin
                    if (half_idx == last_half) begin
                        state_next = ST_HOLD;
                        shift_end  = 1'b1;
                    end else begin
                        sck_event = 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (half_end) begin
                    frame_end  = 1'b1;
                    state_next = last_q ? ST_IDLE : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (hs) state_next = ST_SETUP;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Datapath: config latch, divider, SCK, shift registers and pin outputs.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cpol_q       <= 1'b0;
            cpha_q       <= 1'b0;
            lsb_q        <= 1'b0;
            mode_q       <= 2'd0;
            div_q        <= '0;
            last_q       <= 1'b0;
            cnt          <= '0;
            half_idx     <= 4'd0;
            tx_sh        <= 8'h00;
            rx_sh        <= 8'h00;
            rx_valid_o   <= 1'b0;
            rx_data_o    <= 8'h00;
            done_o       <= 1'b0;
            spi_sck_o    <= 1'b0;
            spi_nss_o    <= {NSS_NUM{1'b1}};
            spi_io_en_o  <= 4'b0000;
            spi_io_out_o <= 4'b0000;
        end else begin
            rx_valid_o <= 1'b0;
            done_o     <= 1'b0;
            if (tx_ready_o) begin
                spi_sck_o <= ((state == ST_WAIT) && !hs) ? cpol_q : cpol_i;
            end
            if (hs) begin
                cpol_q      <= cpol_i;
                cpha_q      <= cpha_i;
                lsb_q       <= lsb_i;
                mode_q      <= mode_in;
                div_q       <= div_i;
                last_q      <= tx_last_i;
                cnt         <= div_i;
                rx_sh       <= 8'h00;
                spi_io_en_o <= lane_en(mode_in, rxonly_i);
                if (cpha_i) begin
                    tx_sh        <= tx_data_i;
                    spi_io_out_o <= 4'b0000;
                end else begin
                    tx_sh        <= tx_shift(tx_data_i, mode_in, lsb_i);
                    spi_io_out_o <= tx_group(tx_data_i, mode_in, lsb_i);
                end
                if (state == ST_IDLE) begin
                    spi_nss_o <= ~nss_sel_i;
                end
            end
            if ((state == ST_SETUP) || (state == ST_SHIFT) || (state == ST_HOLD)) begin
                cnt <= half_end ? div_q : cnt - 1'b1;
            end
            if ((state == ST_SETUP) && half_end) begin
                half_idx <= 4'd0;
            end else if (sck_event) begin
                half_idx <= half_idx + 4'd1;
            end
            if (sck_event) begin
                spi_sck_o <= ~spi_sck_o;
            end
            if (do_drive) begin
                spi_io_out_o <= tx_group(tx_sh, mode_q, lsb_q);
                tx_sh        <= tx_shift(tx_sh, mode_q, lsb_q);
            end
            if (do_sample) begin
                rx_sh <= rx_insert(rx_sh, spi_io_in_i, mode_q, lsb_q);
            end
            if (shift_end) begin
                spi_io_en_o  <= 4'b0000;
                spi_io_out_o <= 4'b0000;
            end
            if (frame_end) begin
                rx_valid_o <= 1'b1;
                rx_data_o  <= rx_sh;
                if (last_q) begin
                    spi_nss_o <= {NSS_NUM{1'b1}};
                    done_o    <= 1'b1;
                end
            end
        end
    end

endmodule
